// File: rtl/jt10_adpcma_core.sv
// Six-channel ADPCM-A playback core: round-robin ROM fetch, nibble decode into
// 12-bit accumulators, and a saturated 16-bit mix refreshed once per frame.
module jt10_adpcma_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen6,
  input  logic [15:0] addr_in,
  input  logic [2:0]  addr_ch,
  input  logic        up_start,
  input  logic        up_end,
  input  logic [5:0]  aon,
  input  logic [5:0]  aoff,
  input  logic [7:0]  datain,
  input  logic [5:0]  ch_enable,
  input  logic [5:0]  clr_flags,
  output logic [23:0] rom_addr,
  output logic        roe_n,
  output logic [5:0]  flags,
  output logic [15:0] pcm_out
);

  function automatic logic [10:0] step_of(input logic [5:0] idx);
    logic [10:0] s;
    case (idx)
      6'd0:  s = 11'd16;   6'd1:  s = 11'd17;   6'd2:  s = 11'd19;   6'd3:  s = 11'd21;
      6'd4:  s = 11'd23;   6'd5:  s = 11'd25;   6'd6:  s = 11'd28;   6'd7:  s = 11'd31;
      6'd8:  s = 11'd34;   6'd9:  s = 11'd37;   6'd10: s = 11'd41;   6'd11: s = 11'd45;
      6'd12: s = 11'd50;   6'd13: s = 11'd55;   6'd14: s = 11'd60;   6'd15: s = 11'd66;
      6'd16: s = 11'd73;   6'd17: s = 11'd80;   6'd18: s = 11'd88;   6'd19: s = 11'd97;
      6'd20: s = 11'd107;  6'd21: s = 11'd118;  6'd22: s = 11'd130;  6'd23: s = 11'd143;
      6'd24: s = 11'd157;  6'd25: s = 11'd173;  6'd26: s = 11'd190;  6'd27: s = 11'd209;
      6'd28: s = 11'd230;  6'd29: s = 11'd253;  6'd30: s = 11'd279;  6'd31: s = 11'd307;
      6'd32: s = 11'd337;  6'd33: s = 11'd371;  6'd34: s = 11'd408;  6'd35: s = 11'd449;
      6'd36: s = 11'd494;  6'd37: s = 11'd544;  6'd38: s = 11'd598;  6'd39: s = 11'd658;
      6'd40: s = 11'd724;  6'd41: s = 11'd796;  6'd42: s = 11'd876;  6'd43: s = 11'd963;
      6'd44: s = 11'd1060; 6'd45: s = 11'd1166; 6'd46: s = 11'd1282; 6'd47: s = 11'd1411;
      6'd48: s = 11'd1552;
      default: s = 11'd0;
    endcase
    return s;
  endfunction

  function automatic logic signed [7:0] idx_adj(input logic [2:0] mag);
    logic signed [7:0] a;
    case (mag)
      3'd4:    a = 8'sd2;
      3'd5:    a = 8'sd5;
      3'd6:    a = 8'sd7;
      3'd7:    a = 8'sd9;
      default: a = -8'sd1;
    endcase
    return a;
  endfunction

  logic [2:0]         slot_r, slot_s, c_r, c_s;
  logic [15:0]        start_r [6], start_s [6];
  logic [15:0]        end_r [6], end_s [6];
  logic [23:0]        ptr_r [6], ptr_s [6];
  logic [11:0]        acc_r [6], acc_s [6];
  logic [5:0]         idx_r [6], idx_s [6];
  logic [5:0]         on_r, on_s, nib_lo_r, nib_lo_s, flags_r, flags_s, flag_set_s;
  logic [23:0]        rom_addr_r, rom_addr_s;
  logic               roe_n_r, roe_n_s, service_s, end_hit_s;
  logic [15:0]        pcm_r, pcm_s;
  logic [3:0]         nib_s;
  logic [10:0]        step_s;
  logic [14:0]        prod_s;
  logic [11:0]        diff_s, acc_new_s;
  logic signed [7:0]  idx_sum_s;
  logic [5:0]         idx_new_s;
  logic signed [17:0] sum_s;
  logic signed [19:0] scaled_s;

  // Next-state computation for the whole core; the register block only latches it on ticks.
  always_comb begin
    if (slot_r == 3'd5) begin
      slot_s = 3'd0;
      c_s    = (c_r == 3'd5) ? 3'd0 : c_r + 3'd1;
    end else begin
      slot_s = slot_r + 3'd1;
      c_s    = c_r;
    end

    service_s = (slot_r == 3'd5) && on_r[c_r];
    nib_s     = nib_lo_r[c_r] ? datain[3:0] : datain[7:4];
    step_s    = step_of(idx_r[c_r]);
    prod_s    = {11'd0, nib_s[2:0], 1'b1} * {4'd0, step_s};
    diff_s    = 12'(prod_s >> 3);
    acc_new_s = nib_s[3] ? (acc_r[c_r] - diff_s) : (acc_r[c_r] + diff_s);
    idx_sum_s = $signed({2'b00, idx_r[c_r]}) + idx_adj(nib_s[2:0]);
    if (idx_sum_s < 8'sd0) begin
      idx_new_s = 6'd0;
    end else if (idx_sum_s > 8'sd48) begin
      idx_new_s = 6'd48;
    end else begin
      idx_new_s = idx_sum_s[5:0];
    end
    end_hit_s = nib_lo_r[c_r] && (ptr_r[c_r][23:8] == end_r[c_r]) && (ptr_r[c_r][7:0] == 8'hFF);

    on_s       = on_r;
    nib_lo_s   = nib_lo_r;
    flag_set_s = 6'd0;
    for (int i = 0; i < 6; i++) begin
      start_s[i] = (up_start && addr_ch == 3'(i)) ? addr_in : start_r[i];
      end_s[i]   = (up_end && addr_ch == 3'(i)) ? addr_in : end_r[i];
      ptr_s[i]   = ptr_r[i];
      acc_s[i]   = acc_r[i];
      idx_s[i]   = idx_r[i];

      if (service_s && c_r == 3'(i)) begin
        acc_s[i] = acc_new_s;
        idx_s[i] = idx_new_s;
        if (!nib_lo_r[i]) begin
          nib_lo_s[i] = 1'b1;
        end else if (end_hit_s) begin
          nib_lo_s[i]   = 1'b0;
          on_s[i]       = 1'b0;
          flag_set_s[i] = 1'b1;
        end else begin
          nib_lo_s[i] = 1'b0;
          ptr_s[i]    = ptr_r[i] + 24'd1;
        end
      end else begin
        nib_lo_s[i] = nib_lo_r[i];
      end

      // Key-on takes priority over key-off and over anything the decoder did this tick.
      if (aon[i]) begin
        on_s[i]     = 1'b1;
        ptr_s[i]    = {start_s[i], 8'h00};
        nib_lo_s[i] = 1'b0;
        acc_s[i]    = 12'd0;
        idx_s[i]    = 6'd0;
      end else if (aoff[i]) begin
        on_s[i] = 1'b0;
      end else begin
        on_s[i] = on_s[i];
      end
    end

    flags_s = (flags_r & ~clr_flags) | flag_set_s;

    if (slot_s != 3'd5 && on_s[c_s]) begin
      roe_n_s    = 1'b0;
      rom_addr_s = ptr_s[c_s];
    end else begin
      roe_n_s    = 1'b1;
      rom_addr_s = rom_addr_r;
    end

    sum_s = 18'sd0;
    for (int i = 0; i < 6; i++) begin
      if (on_r[i] && ch_enable[i]) begin
        sum_s = sum_s + $signed({{6{acc_r[i][11]}}, acc_r[i]});
      end else begin
        sum_s = sum_s;
      end
    end
    scaled_s = {sum_s, 2'b00};
    if (slot_r != 3'd0) begin
      pcm_s = pcm_r;
    end else if (scaled_s > 20'sd32767) begin
      pcm_s = 16'h7FFF;
    end else if (scaled_s < -20'sd32768) begin
      pcm_s = 16'h8000;
    end else begin
      pcm_s = scaled_s[15:0];
    end
  end

  // State and output registers, advanced only on clock-enable ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r     <= 3'd0;
      c_r        <= 3'd0;
      on_r       <= 6'd0;
      nib_lo_r   <= 6'd0;
      flags_r    <= 6'd0;
      rom_addr_r <= 24'd0;
      roe_n_r    <= 1'b1;
      pcm_r      <= 16'd0;
      for (int i = 0; i < 6; i++) begin
        start_r[i] <= 16'd0;
        end_r[i]   <= 16'd0;
        ptr_r[i]   <= 24'd0;
        acc_r[i]   <= 12'd0;
        idx_r[i]   <= 6'd0;
      end
    end else if (cen6) begin
      slot_r     <= slot_s;
      c_r        <= c_s;
      on_r       <= on_s;
      nib_lo_r   <= nib_lo_s;
      flags_r    <= flags_s;
      rom_addr_r <= rom_addr_s;
      roe_n_r    <= roe_n_s;
      pcm_r      <= pcm_s;
      for (int i = 0; i < 6; i++) begin
        start_r[i] <= start_s[i];
        end_r[i]   <= end_s[i];
        ptr_r[i]   <= ptr_s[i];
        acc_r[i]   <= acc_s[i];
        idx_r[i]   <= idx_s[i];
      end
    end
  end

  assign rom_addr = rom_addr_r;
  assign roe_n    = roe_n_r;
  assign flags    = flags_r;
  assign pcm_out  = pcm_r;

endmodule

// File: tb/tb_jt10_adpcma_core.sv
// Randomised and directed bench for jt10_adpcma_core, checked every cycle
// against an arithmetic reference model of the playback rules.
module tb_jt10_adpcma_core;

  logic        clk, rst_n, cen6;
  logic [15:0] addr_in;
  logic [2:0]  addr_ch;
  logic        up_start, up_end;
  logic [5:0]  aon, aoff, ch_enable, clr_flags;
  logic [7:0]  datain;
  logic [23:0] rom_addr;
  logic        roe_n;
  logic [5:0]  flags;
  logic [15:0] pcm_out;

  jt10_adpcma_core dut (
    .clk(clk), .rst_n(rst_n), .cen6(cen6), .addr_in(addr_in), .addr_ch(addr_ch),
    .up_start(up_start), .up_end(up_end), .aon(aon), .aoff(aoff), .datain(datain),
    .ch_enable(ch_enable), .clr_flags(clr_flags), .rom_addr(rom_addr), .roe_n(roe_n),
    .flags(flags), .pcm_out(pcm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit seen_min = 1'b0;
  bit seen_max = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int m_start[6], m_end[6], m_ptr[6], m_acc[6], m_idx[6];
  bit m_on[6], m_lo[6];
  bit [5:0] m_flags;
  int m_slot, m_c, m_rom, m_pcm;
  bit m_roe_n;
  int steps[49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,107,118,130,
                    143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,598,658,724,
                    796,876,963,1060,1166,1282,1411,1552};
  int adj[8] = '{-1,-1,-1,-1,2,5,7,9};

  function automatic int wrap12(input int v);
    int r;
    r = ((v % 4096) + 4096) % 4096;
    return (r >= 2048) ? r - 4096 : r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_start[i] = 0; m_end[i] = 0; m_ptr[i] = 0; m_acc[i] = 0; m_idx[i] = 0;
      m_on[i] = 1'b0; m_lo[i] = 1'b0;
    end
    m_flags = 6'd0; m_slot = 0; m_c = 0; m_rom = 0; m_pcm = 0; m_roe_n = 1'b1;
  endtask

  task automatic model_step();
    int sum, n, mag, diff, ni;
    bit [5:0] set;
    set = 6'd0;
    sum = 0;
    for (int i = 0; i < 6; i++)
      if (m_on[i] && ch_enable[i]) sum += m_acc[i];
    sum = sum * 4;
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    if (m_slot == 0) m_pcm = sum;

    for (int i = 0; i < 6; i++) begin
      if (up_start && addr_ch == i) m_start[i] = addr_in;
      if (up_end && addr_ch == i) m_end[i] = addr_in;
    end

    if (m_slot == 5 && m_on[m_c]) begin
      n = m_lo[m_c] ? int'(datain[3:0]) : int'(datain[7:4]);
      mag = n % 8;
      diff = ((2 * mag + 1) * steps[m_idx[m_c]]) / 8;
      m_acc[m_c] = wrap12((n >= 8) ? m_acc[m_c] - diff : m_acc[m_c] + diff);
      ni = m_idx[m_c] + adj[mag];
      m_idx[m_c] = (ni < 0) ? 0 : ((ni > 48) ? 48 : ni);
      if (!m_lo[m_c]) begin
        m_lo[m_c] = 1'b1;
      end else if (m_ptr[m_c] / 256 == m_end[m_c] && m_ptr[m_c] % 256 == 255) begin
        m_on[m_c] = 1'b0; set[m_c] = 1'b1; m_lo[m_c] = 1'b0;
      end else begin
        m_ptr[m_c] = (m_ptr[m_c] + 1) % (1 << 24); m_lo[m_c] = 1'b0;
      end
    end

    m_flags = (m_flags & ~clr_flags) | set;
    for (int i = 0; i < 6; i++) begin
      if (aon[i]) begin
        m_on[i] = 1'b1; m_ptr[i] = m_start[i] * 256; m_lo[i] = 1'b0; m_acc[i] = 0; m_idx[i] = 0;
      end else if (aoff[i]) begin
        m_on[i] = 1'b0;
      end
    end

    if (m_slot == 5) begin m_slot = 0; m_c = (m_c + 1) % 6; end
    else m_slot++;
    if (m_slot < 5 && m_on[m_c]) begin m_roe_n = 1'b0; m_rom = m_ptr[m_c]; end
    else m_roe_n = 1'b1;
  endtask

  task automatic cycle();
    if (!rst_n) model_reset();
    else if (cen6) model_step();
    @(posedge clk);
    #1;
    check_val("rom_addr", {8'h0, rom_addr}, 32'(m_rom));
    check_val("roe_n", {31'h0, roe_n}, {31'h0, m_roe_n});
    check_val("flags", {26'h0, flags}, {26'h0, m_flags});
    check_val("pcm_out", {16'h0, pcm_out}, 32'(m_pcm) & 32'h0000FFFF);
    if (pcm_out == 16'h8000) seen_min = 1'b1;
    if (pcm_out == 16'h7FFF) seen_max = 1'b1;
  endtask

  task automatic run_to(input int slot, input int ch);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(m_slot == slot && m_c == ch) && n < 200);
    if (n >= 200) check_val("run_to_bound", 32'(n), 32'd0);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #2;
    check_val("rst_roe_n", {31'h0, roe_n}, 32'd1);
    check_val("rst_rom_addr", {8'h0, rom_addr}, 32'd0);
    check_val("rst_flags", {26'h0, flags}, 32'd0);
    check_val("rst_pcm", {16'h0, pcm_out}, 32'd0);
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0; cen6 = 1'b0; addr_in = 16'd0; addr_ch = 3'd0; up_start = 1'b0; up_end = 1'b0;
    aon = 6'd0; aoff = 6'd0; datain = 8'd0; ch_enable = 6'd0; clr_flags = 6'd0;
    model_reset();
    repeat (3) cycle();

    // Key-on ch0 from start 0x0012, then two services of byte 0x78
    rst_n = 1'b1; cen6 = 1'b1; ch_enable = 6'h01; datain = 8'h78;
    addr_ch = 3'd0; addr_in = 16'h0012; up_start = 1'b1; cycle(); up_start = 1'b0;
    aon = 6'h01; cycle(); aon = 6'h00;
    check_val("ko_roe_n", {31'h0, roe_n}, 32'd0);
    check_val("ko_rom_addr", {8'h0, rom_addr}, 32'h001200);
    run_to(1, 1);
    check_val("first_pcm", {16'h0, pcm_out}, 32'd120);
    run_to(2, 0);
    check_val("hi_ptr_hold", {8'h0, rom_addr}, 32'h001200);
    run_to(1, 1);
    check_val("second_pcm", {16'h0, pcm_out}, 32'd104);
    run_to(0, 0);
    check_val("ptr_inc", {8'h0, rom_addr}, 32'h001201);
    check_val("ptr_inc_roe", {31'h0, roe_n}, 32'd0);

    // Simultaneous aon/aoff on ch2, then aoff alone
    aon = 6'h04; aoff = 6'h04; cycle(); aon = 6'h00; aoff = 6'h00;
    run_to(0, 2);
    check_val("aon_wins", {31'h0, roe_n}, 32'd0);
    aoff = 6'h04; cycle(); aoff = 6'h00;
    run_to(0, 2);
    check_val("aoff_roe_n", {31'h0, roe_n}, 32'd1);
    check_val("aoff_flag", {31'h0, flags[2]}, 32'd0);

    // Reset while playing
    reset_now();
    repeat (2) cycle();
    rst_n = 1'b1;

    // All channels on nibble 0x8; ch3 runs a single 256-byte block
    ch_enable = 6'h3F; datain = 8'h88;
    for (int i = 0; i < 6; i++) begin
      addr_ch = 3'(i); addr_in = (i == 3) ? 16'h0001 : 16'h1000 + 16'(i);
      up_start = 1'b1; up_end = (i == 3); cycle();
    end
    addr_ch = 3'd7; addr_in = 16'hFFFF; up_end = 1'b1; up_start = 1'b1; cycle();
    up_start = 1'b0; up_end = 1'b0;
    aon = 6'h3F; cycle(); aon = 6'h00;
    repeat (37300) cycle();
    check_val("end_flag3", {26'h0, flags}, 32'h08);
    check_val("sat_min_seen", {31'h0, seen_min}, 32'd1);
    check_val("sat_max_seen", {31'h0, seen_max}, 32'd1);
    clr_flags = 6'h08; cycle(); clr_flags = 6'h00;
    check_val("flag_clear", {26'h0, flags}, 32'd0);

    // Randomised traffic with gated ticks and one reset in the middle
    for (int k = 0; k < 8000; k++) begin
      cen6 = ($urandom_range(0, 3) != 0);
      datain = 8'($urandom);
      aon = 6'd0; aoff = 6'd0; up_start = 1'b0; up_end = 1'b0; clr_flags = 6'd0;
      addr_ch = 3'($urandom);
      addr_in = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 3) aon = 6'($urandom);
      if ($urandom_range(0, 99) < 2) aoff = 6'($urandom);
      if ($urandom_range(0, 99) < 5) up_start = 1'b1;
      if ($urandom_range(0, 99) < 5) up_end = 1'b1;
      if ($urandom_range(0, 99) < 3) clr_flags = 6'($urandom);
      if ($urandom_range(0, 99) < 10) ch_enable = 6'($urandom);
      if (k == 4000) reset_now();
      if (k == 4003) rst_n = 1'b1;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
